// File: rtl/add_pkg.sv
// Shared constants and helpers for the time-shared Add datapath.
package add_pkg;

    localparam int ADD_W    = 32;
    localparam int ADD_NREQ = 4;

    // Width of a requester index: max(1, clog2(n)).
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Add.sv
// The processor's single ADD_W-bit adder. Carry-out is not needed by any user.
module Add
    import add_pkg::*;
#(
    parameter int W = ADD_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);

    // Sum modulo 2^W; the carry chain is left to the adder mapping.
    always_comb begin
        o_sum = i_a + i_b + W'(i_cin);
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr.
module rr_pick
    import add_pkg::*;
#(
    parameter int NREQ = ADD_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_free,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_cand;

    // Walk ptr, ptr+1, ... (mod NREQ) and keep the first valid one; no grant when not free.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % NREQ);
            if (i_free && !o_any && i_req_valid[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one Add among NREQ requesters, with a one-entry
// tagged result register.
//
// Handshakes: a transfer happens at a rising edge when valid and ready are both
// high on the same side; ready never depends on payload data, and a requester's
// payload is sampled only at its transfer edge.
module adder_share_arb
    import add_pkg::*;
#(
    parameter  int NREQ = ADD_NREQ,
    parameter  int W    = ADD_W,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic [IDW-1:0]    rsp_id
);

    logic           r_valid;
    logic [W-1:0]   r_sum;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_ptr;

    logic            w_free;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [W-1:0]    w_a_arr [NREQ];
    logic [W-1:0]    w_b_arr [NREQ];
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;
    logic [W-1:0]    w_sum;

    // The output slot can take a new result if empty or being drained; never during reset.
    always_comb begin
        w_free = !rst && (!r_valid || rsp_ready);
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .i_free      (w_free),
        .o_gnt       (w_gnt),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a_arr[g] = req_a[g*W +: W];
        assign w_b_arr[g] = req_b[g*W +: W];
    end

    // Steer the granted requester's operands into the shared adder.
    always_comb begin
        w_op_a = w_a_arr[w_idx];
        w_op_b = w_b_arr[w_idx];
    end

    Add #(
        .W (W)
    ) u_add (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    // Output register and priority pointer: capture on grant, clear on bare drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_any) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_id    <= w_idx;
            r_ptr   <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter that time-shares the processor's single 32-bit ripple-carry `Add` datapath among several requesters, such as PC increment, branch-target and address generation. Each requester uses a valid/ready handshake. The granted operand pair is added in one cycle and the sum is captured in a one-entry output register, tagged with the requester index. Throughput is one addition per cycle whenever the output is drained.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 32: operand width. It is fixed to the `Add` width; the only legal value is 32.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: requester i presents operands.
- `req_ready` out NREQ: one-hot or zero; requester i's operands are accepted this cycle.
- `req_a` in NREQ*W: operand A of requester i, in bits [i*W +: W].
- `req_b` in NREQ*W: operand B of requester i, in bits [i*W +: W].
- `rsp_valid` out 1: the output register holds a result.
- `rsp_ready` in 1: the consumer takes the result this cycle.
- `rsp_sum` out W: (A + B) mod 2^32; carry-out is discarded.
- `rsp_id` out IDW: index of the requester that produced `rsp_sum`. IDW = max(1, clog2(NREQ)).

## Operation
- Reset values:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0.
  - Priority pointer `ptr`=0.
  - `req_ready`=0 while `rst` is high.
- Free condition: `free` = !`rsp_valid` || `rsp_ready`.
- Grant selection:
  - When `free` is high, grant the first i with `req_valid[i]`=1, searching `ptr`, `ptr`+1, …, wrapping mod NREQ.
  - `req_ready[i]`=1 only for the granted requester.
  - When `free` is low, all `req_ready` bits are 0.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. It never depends on operand data.
- Datapath:
  - A mux selects the granted `req_a`/`req_b` into a single `Add` instance with carry-in 0.
  - The `Add` output is captured at the edge where `req_ready[i]`=1.
- On a transfer (`req_valid[i]` && `req_ready[i]`) at an edge:
  - `rsp_sum` ← sum.
  - `rsp_id` ← i.
  - `rsp_valid` ← 1.
  - `ptr` ← (i+1) mod NREQ.
- Drain without a new grant (`rsp_valid` && `rsp_ready`, no request granted): `rsp_valid` ← 0; `rsp_sum` and `rsp_id` hold their values.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and `rsp_valid` stays 1 (no bubble).
- Consumer stall:
  - `rsp_valid`=1 and `rsp_ready`=0 means `rsp_sum` and `rsp_id` are held stable and all `req_ready` bits are 0.
  - `ptr` does not move.
- Requester obligation: hold `req_valid`, `req_a` and `req_b` stable until `req_ready` is asserted. The arbiter's grant remains correct if a requester violates this; no data is latched before the transfer.
- Fairness: a requester holding `req_valid` is granted within NREQ transfers.
- Reset asserted mid-operation:
  - Any pending result is dropped and `rsp_valid` goes to 0 immediately (asynchronously).
  - `ptr` returns to 0.
  - There is no partial state to recover.

## Timing
- Latency: 1 cycle. Operands accepted at edge N appear on `rsp_sum` after edge N, with `rsp_valid`=1 during cycle N+1.
- Throughput: 1 result per cycle when `rsp_ready` is held at 1.
- Critical path: `ptr` → grant → operand mux → 32-bit ripple carry → `rsp_sum` register. This must close at the core clock.
- Reset deassertion is synchronised externally; the block has no reset-release requirement of its own.

## Structure
- Shared package `add_pkg`:
  - Constants `ADD_W`=32 and `ADD_NREQ`=4.
  - A function computing IDW.
- Sub-module `rr_pick`: combinational round-robin priority picker. It takes `req_valid`, `ptr` and `free`, and outputs a one-hot grant plus the encoded index.
- Top level:
  - Instantiates `rr_pick` and one `Add`.
  - Holds the output register and `ptr` in a single sequential process with asynchronous reset.

## Test plan
1. Reset, then idle:
   - `rst` pulsed for 3 cycles, no requests → `rsp_valid`=0 and `req_ready`=0 throughout.
   - `rsp_sum`=0 and `rsp_id`=0.
2. Single request:
   - Req 2 sends A=0x0000_0005, B=0x0000_0007, with `rsp_ready`=1.
   - → `req_ready[2]`=1 in cycle 0.
   - → Cycle 1: `rsp_valid`=1, `rsp_sum`=0x0000_000C, `rsp_id`=2.
3. Wrap-around:
   - A=0xFFFF_FFFF, B=0x0000_0001 → `rsp_sum`=0x0000_0000.
   - A=0x8000_0000, B=0x8000_0000 → `rsp_sum`=0.
4. Round-robin fairness:
   - All 4 requesters valid continuously, `rsp_ready`=1.
   - → `rsp_id` sequence 0,1,2,3,0,… with one result per cycle and no bubbles.
5. Backpressure:
   - Result pending, `rsp_ready`=0 for 5 cycles while reqs 1 and 3 are valid.
   - → `req_ready`=0 and `rsp_sum`/`rsp_id` stable for those 5 cycles.
   - → On release: the old result is drained and req 1 is granted in the same cycle; req 3 follows in the next cycle.
6. Reset mid-stream:
   - Assert `rst` while `rsp_valid`=1 and `ptr`=2.
   - → `rsp_valid`=0 immediately.
   - → After release with all requesters valid, the first `rsp_id` is 0.
